multiplicador_sequencial: RTL and testbench

//   Parametrised shift-and-add multiplier, successor to the combinational ROM multiplier.

---
 rtl/multiplicador_sequencial.sv | 117 +++++++++++
 tb/tb_multiplicador_sequencial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_sequencial.sv
// Shift-and-add unsigned multiplier: N-bit x N-bit -> 2N-bit product in N iterations.
// Start/done handshake: Iniciar is accepted only while Pronto=1; Fim pulses for one cycle
// when Produto has just been updated. Produto holds until the next completed operation.
module multiplicador_sequencial #(
  parameter int unsigned N = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           Iniciar,
  input  logic [2*N-1:0] Fatores,
  output logic           Pronto,
  output logic           Fim,
  output logic [2*N-1:0] Produto
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StOcioso  = 2'd0,
    StCalcula = 2'd1,
    StFim     = 2'd2
  } estado_e;

  estado_e         r_estado;
  estado_e         w_estado_prox;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [2*N-1:0]  r_acc;
  logic [CntW-1:0] r_cnt;
  logic [2*N-1:0]  r_produto;

  logic            w_aceita;
  logic            w_ultimo;
  logic [2*N-1:0]  w_parcial;
  logic [2*N-1:0]  w_acc_prox;

  // Start is only honoured when idle; requests in other states are dropped, not queued.
  assign w_aceita = (r_estado == StOcioso) && Iniciar;
  assign w_ultimo = (r_estado == StCalcula) && (r_cnt == CntLast);

  // Partial product for the current iteration: A weighted by the bit position of B[0].
  always_comb begin
    w_parcial  = {{N{1'b0}}, r_a} << r_cnt;
    w_acc_prox = r_acc;
    if (r_b[0]) begin
      w_acc_prox = r_acc + w_parcial;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= StOcioso;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next-state logic: fixed N-cycle CALCULA, one-cycle FIM, then back to idle.
  always_comb begin
    w_estado_prox = r_estado;
    unique case (r_estado)
      StOcioso: begin
        if (Iniciar) begin
          w_estado_prox = StCalcula;
        end
      end
      StCalcula: begin
        if (r_cnt == CntLast) begin
          w_estado_prox = StFim;
        end
      end
      StFim: begin
        w_estado_prox = StOcioso;
      end
      default: begin
        w_estado_prox = StOcioso;
      end
    endcase
  end

  // Operand, accumulator and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_aceita) begin
      r_a   <= Fatores[2*N-1:N];
      r_b   <= Fatores[N-1:0];
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_estado == StCalcula) begin
      r_acc <= w_acc_prox;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result register: loaded with the final accumulation on the edge that enters FIM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_produto <= '0;
    end else if (w_ultimo) begin
      r_produto <= w_acc_prox;
    end
  end

  // Handshake outputs are pure decodes of the state register, so they are glitch-free
  // and mutually exclusive.
  assign Pronto  = (r_estado == StOcioso);
  assign Fim     = (r_estado == StFim);
  assign Produto = r_produto;

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed bench for multiplicador_sequencial: a 5-bit instance for most scenarios and an
// 8-bit instance for the continuous-start case. Expected products go through a queue.
module tb_multiplicador_sequencial;

  localparam int N = 5;
  localparam int M = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           iniciar;
  logic [2*N-1:0] fatores;
  logic           pronto;
  logic           fim;
  logic [2*N-1:0] produto;

  logic           reset8;
  logic           iniciar8;
  logic [2*M-1:0] fatores8;
  logic           pronto8;
  logic           fim8;
  logic [2*M-1:0] produto8;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  multiplicador_sequencial #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .Iniciar (iniciar),
    .Fatores (fatores),
    .Pronto  (pronto),
    .Fim     (fim),
    .Produto (produto)
  );

  multiplicador_sequencial #(.N(M)) dut8 (
    .clock   (clock),
    .reset   (reset8),
    .Iniciar (iniciar8),
    .Fatores (fatores8),
    .Pronto  (pronto8),
    .Fim     (fim8),
    .Produto (produto8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one operation on the 5-bit DUT and check latency, result, hold and pulse width.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    int             lat;
    int             guard;
    logic           estavel;
    logic [2*N-1:0] anterior;
    logic [31:0]    esperado;
    guard = 0;
    while (!pronto && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, "_pronto"}, {31'd0, pronto}, 32'd1);
    anterior = produto;
    fatores  = {a, b};
    iniciar  = 1'b1;
    exp_q.push_back(32'(a) * 32'(b));
    @(negedge clock);
    iniciar = 1'b0;
    lat     = 1;
    estavel = 1'b1;
    while (!fim && lat < 30) begin
      if (produto !== anterior) estavel = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk({tag, "_held"}, {31'd0, estavel}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
    esperado = exp_q.pop_front();
    chk({tag, "_produto"}, 32'(produto), esperado);
    chk({tag, "_pronto_in_fim"}, {31'd0, pronto}, 32'd0);
    @(negedge clock);
    chk({tag, "_fim_one_cycle"}, {31'd0, fim}, 32'd0);
    chk({tag, "_produto_kept"}, 32'(produto), esperado);
  endtask

  initial begin
    int   nfim;
    int   guard;
    int   gap;
    logic [31:0] esperado;

    reset    = 1'b1;
    iniciar  = 1'b0;
    fatores  = '0;
    reset8   = 1'b1;
    iniciar8 = 1'b0;
    fatores8 = '0;

    // 1: reset two cycles
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_pronto", {31'd0, pronto}, 32'd1);
    chk("reset_fim", {31'd0, fim}, 32'd0);
    chk("reset_produto", 32'(produto), 32'd0);

    // 2: 10 x 10
    run_op(5'd10, 5'd10, "t2_10x10");

    // 3: sequence
    run_op(5'd31, 5'd31, "t3_31x31");
    run_op(5'd27, 5'd19, "t3_27x19");
    run_op(5'd15, 5'd19, "t3_15x19");
    run_op(5'd13, 5'd7,  "t3_13x7");
    run_op(5'd9,  5'd22, "t3_9x22");
    run_op(5'd10, 5'd0,  "t3_10x0");

    // 4: 7 x 7 with a 3 x 3 re-pulse during CALCULA
    fatores = {5'd7, 5'd7};
    iniciar = 1'b1;
    exp_q.push_back(32'd49);
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    fatores = {5'd3, 5'd3};
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    nfim = 0;
    esperado = exp_q.pop_front();
    for (int i = 0; i < 2 * N + 6; i++) begin
      if (fim) begin
        nfim++;
        chk("t4_produto", 32'(produto), esperado);
      end
      @(negedge clock);
    end
    chk("t4_single_fim", 32'(nfim), 32'd1);

    // 5: reset in the third CALCULA cycle of 31 x 31
    fatores = {5'd31, 5'd31};
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_pronto", {31'd0, pronto}, 32'd1);
    chk("t5_produto", 32'(produto), 32'd0);
    nfim = 0;
    for (int i = 0; i < N + 3; i++) begin
      if (fim) nfim++;
      @(negedge clock);
    end
    chk("t5_no_fim", 32'(nfim), 32'd0);
    run_op(5'd2, 5'd3, "t5_2x3");

    // 6: N=8, 255 x 255 with Iniciar held high
    @(negedge clock);
    reset8 = 1'b0;
    fatores8 = {8'd255, 8'd255};
    iniciar8 = 1'b1;
    guard = 0;
    while (!fim8 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    chk("t6_first_fim", {31'd0, fim8}, 32'd1);
    chk("t6_produto", 32'(produto8), 32'd65025);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      gap = 1;
      while (!fim8 && gap < 40) begin
        @(negedge clock);
        gap++;
      end
      chk("t6_period", 32'(gap), 32'(M + 2));
      chk("t6_produto_rep", 32'(produto8), 32'd65025);
    end
    iniciar8 = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
